// File: rtl/rhythm_pkg.sv
// Shared types and constants for the multi-lane rhythm judge.
//   judge_t      : judgement code carried on judge_result
//   BONUS_THRESH : combo level at which a hit earns one extra point
//                  (used only when COMBO_BONUS_EN is defined)
package rhythm_pkg;

  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_t;

  localparam int BONUS_THRESH = 10;

endpackage

// File: rtl/rhythm_lane_queue.sv
// Per-lane pending-note FIFO holding note timestamps.
//   clock, reset : system clock, synchronous active-high reset
//   push, din    : enqueue din (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head         : oldest timestamp, meaningful only while !empty
//   empty, full  : occupancy flags
// DEPTH must be a power of two, at least 2.
module rhythm_lane_queue #(
  parameter int TS_W  = 10,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [TS_W-1:0] din,
  output logic [TS_W-1:0] head,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]     wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rhythm_judge_engine.sv
// N-lane rhythm-game judge: buffers timestamped notes per lane, grades key
// presses against game_time as PERFECT / GOOD / MISS, and keeps a saturating
// score, current combo and max combo.
//   clock, reset      : system clock, synchronous active-high reset
//   game_time         : running game timer (monotonic between resets)
//   note_valid/ready  : note handshake; note_lane/note_time carry the note
//   key_in            : raw key levels, 1 = pressed
//   judge_valid       : one-cycle pulse per judgement, with judge_lane/result
//   score, combo, max_combo : running totals, updated with judge_valid
// Optional feature macro: COMBO_BONUS_EN -- hits made with a pre-increment
// combo >= BONUS_THRESH earn one extra point.
module rhythm_judge_engine
  import rhythm_pkg::*;
#(
  parameter int N_LANES     = 4,
  parameter int TS_W        = 10,
  parameter int DEPTH       = 4,
  parameter int PERFECT_WIN = 2,
  parameter int GOOD_WIN    = 6,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int SCORE_W     = 11,
  parameter int CMB_W       = 8,
  localparam int LW         = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [TS_W-1:0]    game_time,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [LW-1:0]      note_lane,
  input  logic [TS_W-1:0]    note_time,
  input  logic [N_LANES-1:0] key_in,
  output logic               judge_valid,
  output logic [LW-1:0]      judge_lane,
  output logic [1:0]         judge_result,
  output logic [SCORE_W-1:0] score,
  output logic [CMB_W-1:0]   combo,
  output logic [CMB_W-1:0]   max_combo
);

  localparam logic        [TS_W:0] PERFECT_MAG = (TS_W+1)'(PERFECT_WIN);
  localparam logic        [TS_W:0] GOOD_MAG    = (TS_W+1)'(GOOD_WIN);
  localparam logic signed [TS_W:0] GOOD_DIFF   = (TS_W+1)'(GOOD_WIN);

  // Raw keys are registered once before edge detection, so a press sampled
  // at edge t is judged into the pending flag at t+1 and reported at t+2.
  logic [N_LANES-1:0] key_s, key_q, press;
  assign press = key_s & ~key_q;

  logic [N_LANES-1:0]            q_push, q_pop, q_empty, q_full;
  logic [N_LANES-1:0][TS_W-1:0]  q_head;
  logic [N_LANES-1:0][1:0]       lane_res;
  logic [N_LANES-1:0]            pending;
  logic [N_LANES-1:0][1:0]       pend_res;

  // ---------------------------------------------------------------- notes
  // Out-of-range lanes are accepted and dropped so they cannot wedge the bus.
  logic lane_ok;
  assign lane_ok    = (int'(note_lane) < N_LANES);
  assign note_ready = !reset && (!lane_ok || !q_full[note_lane]);

  // ---------------------------------------------------------------- lanes
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic signed [TS_W:0] diff;
    logic        [TS_W:0] mag;
    logic                 armed, hit_p, hit_g, late;

    assign q_push[g] = note_valid && note_ready && lane_ok && (note_lane == LW'(g));

    rhythm_lane_queue #(.TS_W(TS_W), .DEPTH(DEPTH)) u_queue (
      .clock (clock),
      .reset (reset),
      .push  (q_push[g]),
      .pop   (q_pop[g]),
      .din   (note_time),
      .head  (q_head[g]),
      .empty (q_empty[g]),
      .full  (q_full[g])
    );

    // Positive diff means the press (or the clock) is late relative to the note.
    assign diff  = $signed({1'b0, game_time}) - $signed({1'b0, q_head[g]});
    assign mag   = diff[TS_W] ? $unsigned(-diff) : $unsigned(diff);
    assign armed = !q_empty[g] && !pending[g];
    assign hit_p = press[g] && (mag <= PERFECT_MAG);
    assign hit_g = press[g] && (mag <= GOOD_MAG);
    assign late  = (diff > GOOD_DIFF);

    // A press outside the window consumes nothing; a stale note still misses.
    assign lane_res[g] = !armed ? J_NONE    :
                         hit_p  ? J_PERFECT :
                         hit_g  ? J_GOOD    :
                         late   ? J_MISS    : J_NONE;
    assign q_pop[g]    = (lane_res[g] != J_NONE);
  end

  // -------------------------------------------------------------- arbiter
  logic          grant_any;
  logic [LW-1:0] grant_idx;
  logic [1:0]    grant_res;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_any = 1'b1;
        grant_idx = LW'(i);
      end
    end
  end

  assign grant_res = pend_res[grant_idx];

  // ---------------------------------------------------------------- score
  logic               hit_out, miss_out;
  logic [SCORE_W:0]   add_pts, sum;
  logic [SCORE_W-1:0] score_nxt;
  logic [CMB_W-1:0]   combo_nxt, max_nxt;

  assign hit_out  = grant_any && ((grant_res == J_PERFECT) || (grant_res == J_GOOD));
  assign miss_out = grant_any && (grant_res == J_MISS);

  always_comb begin
    add_pts = '0;
    if (hit_out) begin
      add_pts = (grant_res == J_PERFECT) ? (SCORE_W+1)'(PERFECT_PTS) : (SCORE_W+1)'(GOOD_PTS);
`ifdef COMBO_BONUS_EN
      if (combo >= CMB_W'(BONUS_THRESH)) add_pts = add_pts + 1'b1;
`endif
    end
  end

  assign sum       = {1'b0, score} + add_pts;
  assign score_nxt = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  always_comb begin
    combo_nxt = combo;
    if (hit_out && (combo != '1)) combo_nxt = combo + 1'b1;
    else if (miss_out)            combo_nxt = '0;
  end

  assign max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;

  // ------------------------------------------------------------ registers
  always_ff @(posedge clock) begin
    if (reset) begin
      key_s        <= '0;
      key_q        <= '0;
      pending      <= '0;
      pend_res     <= '0;
      judge_valid  <= 1'b0;
      judge_lane   <= '0;
      judge_result <= J_NONE;
      score        <= '0;
      combo        <= '0;
      max_combo    <= '0;
    end else begin
      key_s        <= key_in;
      key_q        <= key_s;
      judge_valid  <= grant_any;
      judge_lane   <= grant_idx;
      judge_result <= grant_any ? grant_res : J_NONE;
      score        <= score_nxt;
      combo        <= combo_nxt;
      max_combo    <= max_nxt;
      // A lane only judges while its flag is clear, so set and clear never
      // collide on the same lane.
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_res[i] != J_NONE) begin
          pending[i]  <= 1'b1;
          pend_res[i] <= lane_res[i];
        end else if (grant_any && (grant_idx == LW'(i))) begin
          pending[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhythm_judge_engine.sv
module tb_rhythm_judge_engine;
  import rhythm_pkg::*;

  typedef struct packed {
    logic [1:0]  lane;
    logic [1:0]  res;
    logic [10:0] score;
    logic [7:0]  combo;
    logic [7:0]  maxc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  game_time;
  logic        note_valid;
  logic        note_ready;
  logic [1:0]  note_lane;
  logic [9:0]  note_time;
  logic [3:0]  key_in;
  logic        judge_valid;
  logic [1:0]  judge_lane;
  logic [1:0]  judge_result;
  logic [10:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  rhythm_judge_engine dut (
    .clock        (clock),
    .reset        (reset),
    .game_time    (game_time),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .note_lane    (note_lane),
    .note_time    (note_time),
    .key_in       (key_in),
    .judge_valid  (judge_valid),
    .judge_lane   (judge_lane),
    .judge_result (judge_result),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   m_score, m_combo, m_max;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference scoring: pushes the expected judgement and totals.
  task automatic model_judge(input logic [1:0] lane, input logic [1:0] res);
    exp_t e;
    int   pts;
    pts = 0;
    if (res == J_PERFECT) pts = 3;
    else if (res == J_GOOD) pts = 1;
    if (res == J_MISS) m_combo = 0;
    else begin
`ifdef COMBO_BONUS_EN
      if (m_combo >= 10) pts = pts + 1;
`endif
      m_score = (m_score + pts > 2047) ? 2047 : m_score + pts;
      m_combo = (m_combo == 255) ? 255 : m_combo + 1;
    end
    if (m_combo > m_max) m_max = m_combo;
    e.lane  = lane;
    e.res   = res;
    e.score = 11'(m_score);
    e.combo = 8'(m_combo);
    e.maxc  = 8'(m_max);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
    exp_q.delete();
  endtask

  task automatic push_note(input logic [1:0] lane, input logic [9:0] t);
    note_valid = 1'b1;
    note_lane  = lane;
    note_time  = t;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic release_keys();
    key_in = '0;
    tick();
    tick();
  endtask

  // Ticks until judge_valid is seen or the budget runs out; lat counts ticks.
  task automatic wait_judge(input int budget, output bit got, output int lat, output exp_t obs);
    got = 1'b0;
    lat = 0;
    obs = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (judge_valid === 1'b1) begin
        got = 1'b1;
        lat = i;
        obs = {judge_lane, judge_result, score, combo, max_combo};
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; game_time = '0; note_valid = 1'b0; note_lane = '0;
    note_time = '0; key_in = '0;
    tick(); tick(); tick();
    tests++;
    if (note_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_low: got %b want 0", note_ready);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({judge_valid, score, combo, max_combo, note_ready} !== {1'b0, 11'd0, 8'd0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: jv=%b score=%0d combo=%0d max=%0d ready=%b want 0 0 0 0 1",
               judge_valid, score, combo, max_combo, note_ready);
    end
    model_reset();
  endtask

  task automatic test_perfect();
    bit got; int lat; exp_t obs, e;
    game_time = 10'd100;
    push_note(2'd0, 10'd100);
    game_time = 10'd101;
    key_in[0] = 1'b1;
    model_judge(2'd0, J_PERFECT);
    wait_judge(8, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL perfect_judge: no judge_valid within 8 cycles");
    end else if (obs !== e) begin
      fails++; $display("FAIL perfect_judge: got %h want %h", obs, e);
    end
    tests++;
    if (lat != 3) begin
      fails++; $display("FAIL perfect_latency: got %0d cycles want 3", lat);
    end
    release_keys();
  endtask

  task automatic test_good_empty();
    bit got; int lat; exp_t obs, e;
    game_time = 10'd200;
    push_note(2'd0, 10'd200);
    game_time = 10'd205;
    key_in[0] = 1'b1;
    model_judge(2'd0, J_GOOD);
    wait_judge(8, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL good_judge: no judge_valid within 8 cycles");
    end else if (obs !== e) begin
      fails++; $display("FAIL good_judge: got %h want %h", obs, e);
    end
    release_keys();
    key_in[0] = 1'b1;
    wait_judge(6, got, lat, obs);
    tests++;
    if (got) begin
      fails++; $display("FAIL empty_press: got judgement %h want none", obs);
    end
    tests++;
    if (score !== 11'(m_score)) begin
      fails++; $display("FAIL empty_press_score: got %0d want %0d", score, m_score);
    end
    release_keys();
  endtask

  task automatic test_miss();
    bit got; int lat; exp_t obs, e;
    bit early;
    game_time = 10'd300;
    push_note(2'd1, 10'd300);
    early = 1'b0;
    for (int t = 301; t <= 306; t++) begin
      game_time = 10'(t);
      tick();
      if (judge_valid === 1'b1) early = 1'b1;
    end
    tick(); tick();
    if (judge_valid === 1'b1) early = 1'b1;
    tests++;
    if (early) begin
      fails++; $display("FAIL miss_early: got judge_valid=1 within window want 0");
    end
    game_time = 10'd307;
    model_judge(2'd1, J_MISS);
    wait_judge(6, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL miss_judge: no judge_valid within 6 cycles");
    end else if (obs !== e) begin
      fails++; $display("FAIL miss_judge: got %h want %h", obs, e);
    end
  endtask

  task automatic test_full();
    bit got; int lat; exp_t obs, e;
    bit stall_ok;
    game_time = 10'd400;
    for (int k = 0; k < 4; k++) push_note(2'd2, 10'(500 + k));
    note_lane = 2'd2;
    #1;
    tests++;
    if (note_ready !== 1'b0) begin
      fails++; $display("FAIL full_ready_lane2: got %b want 0", note_ready);
    end
    note_lane = 2'd0;
    #1;
    tests++;
    if (note_ready !== 1'b1) begin
      fails++; $display("FAIL full_ready_lane0: got %b want 1", note_ready);
    end
    note_valid = 1'b1; note_lane = 2'd2; note_time = 10'd504;
    stall_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (note_ready !== 1'b0) stall_ok = 1'b0;
    end
    note_valid = 1'b0;
    tests++;
    if (!stall_ok) begin
      fails++; $display("FAIL full_stall: got ready=1 while full want 0");
    end
    game_time = 10'd500;
    key_in[2] = 1'b1;
    model_judge(2'd2, J_PERFECT);
    wait_judge(8, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL full_pop_judge: no judge_valid within 8 cycles");
    end else if (obs !== e) begin
      fails++; $display("FAIL full_pop_judge: got %h want %h", obs, e);
    end
    note_lane = 2'd2;
    #1;
    tests++;
    if (note_ready !== 1'b1) begin
      fails++; $display("FAIL after_pop_ready: got %b want 1", note_ready);
    end
    push_note(2'd2, 10'd504);
    note_lane = 2'd2;
    #1;
    tests++;
    if (note_ready !== 1'b0) begin
      fails++; $display("FAIL refill_ready: got %b want 0", note_ready);
    end
    release_keys();
  endtask

  task automatic test_reset_midsong();
    bit got; int lat; exp_t obs;
    push_note(2'd0, 10'd600);
    reset = 1'b1;
    tick();
    tests++;
    if (note_ready !== 1'b0) begin
      fails++; $display("FAIL midreset_ready_low: got %b want 0", note_ready);
    end
    tick();
    reset = 1'b0;
    note_lane = 2'd2;
    #1;
    tests++;
    if ({judge_valid, score, combo, max_combo, note_ready} !== {1'b0, 11'd0, 8'd0, 8'd0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_state: jv=%b score=%0d combo=%0d max=%0d ready=%b want 0 0 0 0 1",
               judge_valid, score, combo, max_combo, note_ready);
    end
    model_reset();
    game_time = 10'd501;
    key_in[2] = 1'b1;
    wait_judge(6, got, lat, obs);
    tests++;
    if (got) begin
      fails++; $display("FAIL midreset_queue_empty: got judgement %h want none", obs);
    end
    release_keys();
  endtask

  task automatic test_back_to_back();
    bit got; int lat; exp_t obs, e;
    game_time = 10'd150;
    push_note(2'd0, 10'd150);
    push_note(2'd3, 10'd152);
    game_time = 10'd151;
    key_in = 4'b1001;
    model_judge(2'd0, J_PERFECT);
    model_judge(2'd3, J_PERFECT);
    wait_judge(8, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL dual_first: no judge_valid within 8 cycles");
    end else if (obs !== e) begin
      fails++; $display("FAIL dual_first: got %h want %h", obs, e);
    end
    wait_judge(1, got, lat, obs);
    e = exp_q.pop_front();
    tests++;
    if (!got) begin
      fails++; $display("FAIL dual_second: no judge_valid on next cycle");
    end else if (obs !== e) begin
      fails++; $display("FAIL dual_second: got %h want %h", obs, e);
    end
    release_keys();
  endtask

  task automatic test_combo_run();
    bit got; int lat; exp_t obs, e;
    int bad;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      game_time = 10'(700 + 20 * k);
      push_note(2'd1, 10'(700 + 20 * k));
      key_in[1] = 1'b1;
      model_judge(2'd1, (k % 3 == 1) ? J_GOOD : J_PERFECT);
      if (k % 3 == 1) game_time = 10'(704 + 20 * k);
      wait_judge(8, got, lat, obs);
      e = exp_q.pop_front();
      if (!got || obs !== e) begin
        bad++;
        $display("FAIL combo_run_%0d: got %h (valid %b) want %h", k, obs, got, e);
      end
      release_keys();
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (max_combo !== 8'(m_max)) begin
      fails++; $display("FAIL combo_run_max: got %0d want %0d", max_combo, m_max);
    end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_good_empty();
    test_miss();
    test_full();
    test_reset_midsong();
    test_back_to_back();
    test_combo_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
